// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all domain resets together, then releases them in index order.
// Latency: domain 0 is released dly_cfg+1 edges after reset ends; each later domain follows its predecessor's ack by dly_cfg+2 edges.
// Backpressure: each release waits for that domain's ack, or for TO_CYC cycles before a sticky timeout flag is set.
module rst_seq_ctrl #(
  parameter int NUM_DOM = 4,
  parameter int CNT_W   = 8,
  parameter int TO_CYC  = 32
) (
  input  logic                       clk,
  input  logic                       sync_rst_n,   // active-high asynchronous reset
  input  logic                       sw_rst_req,
  input  logic [CNT_W-1:0]           dly_cfg,
  input  logic [NUM_DOM-1:0]         dom_ack,
  output logic [NUM_DOM-1:0]         dom_rst_n,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic [$clog2(NUM_DOM)-1:0] cur_dom
);

  localparam int DOM_W = $clog2(NUM_DOM);
  localparam int TO_W  = $clog2(TO_CYC);
  localparam logic [DOM_W-1:0] LAST_DOM = DOM_W'(NUM_DOM - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

  typedef enum logic [1:0] {
    ST_GAP      = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge sync_rst_n) begin
    if (sync_rst_n) begin
      state       <= ST_GAP;
      dom_rst_n   <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cur_dom     <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
    end else if (sw_rst_req) begin
      // A held request parks the block here with counters cleared.
      state       <= ST_GAP;
      dom_rst_n   <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cur_dom     <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      case (state)
        ST_GAP: begin
          // dly_cfg is compared live; a counter already past it wraps around.
          if (gap_cnt == dly_cfg) begin
            dom_rst_n[cur_dom] <= 1'b1;
            to_cnt             <= '0;
            state              <= ST_WAIT_ACK;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          // An ack on the expiry edge wins over the timeout.
          if (dom_ack[cur_dom] || (to_cnt == TO_LAST)) begin
            if (!dom_ack[cur_dom]) begin
              timeout_err <= 1'b1;
            end
            if (cur_dom == LAST_DOM) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              dom_rst_n <= '1;
            end else begin
              cur_dom <= cur_dom + 1'b1;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          dom_rst_n <= '1;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          state <= ST_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with NUM_DOM=4, CNT_W=8, TO_CYC=32.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
// Expected values are hand-derived release edges and flag states.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       sync_rst_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [7:0] dly_cfg = 8'd3;
  logic [3:0] dom_ack = 4'b1111;
  logic [3:0] dom_rst_n;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [1:0] cur_dom;

  int n_chk  = 0;
  int n_pass = 0;

  rst_seq_ctrl #(.NUM_DOM(4), .CNT_W(8), .TO_CYC(32)) dut (
    .clk         (clk),
    .sync_rst_n  (sync_rst_n),
    .sw_rst_req  (sw_rst_req),
    .dly_cfg     (dly_cfg),
    .dom_ack     (dom_ack),
    .dom_rst_n   (dom_rst_n),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .cur_dom     (cur_dom)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert the hardware reset, check the reset state, release it off-edge.
  task automatic hw_reset();
    sync_rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_dom_rst_n", dom_rst_n, 4'b0000);
    chk("rst_busy", busy, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_cur_dom", cur_dom, 2'd0);
    sync_rst_n = 1'b0;
  endtask

  // Acks tied high: domain k releases on edge (d+1)+k*(d+2), done one edge after the last.
  task automatic check_seq(input int d, input string tag);
    int done_edge;
    logic [3:0] exp_mask;
    done_edge = (d + 1) + 3 * (d + 2) + 1;
    for (int e = 1; e <= done_edge; e++) begin
      tick();
      exp_mask = '0;
      for (int k = 0; k < 4; k++)
        if (e >= (d + 1) + k * (d + 2)) exp_mask[k] = 1'b1;
      chk({tag, "_dom_rst_n"}, dom_rst_n, exp_mask);
      chk({tag, "_busy"}, busy, (e < done_edge) ? 1'b1 : 1'b0);
      chk({tag, "_done"}, done, (e < done_edge) ? 1'b0 : 1'b1);
    end
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
    chk({tag, "_cur_dom_end"}, cur_dom, 2'd3);
  endtask

  initial begin
    // 1: power-on, dly_cfg=3, acks high -> releases at edges 4, 9, 14, 19; done at 20.
    dly_cfg = 8'd3;
    dom_ack = 4'b1111;
    hw_reset();
    check_seq(3, "s1");

    // 2: dom_ack[2] stuck low. Release 2 at edge 14, timeout at 46, release 3 at 50, done at 51.
    dom_ack = 4'b1011;
    hw_reset();
    tick_n(14);
    chk("s2_rel2", dom_rst_n, 4'b0111);
    chk("s2_cur_dom2", cur_dom, 2'd2);
    tick_n(31);
    chk("s2_pre_to_err", timeout_err, 1'b0);
    chk("s2_pre_to_cur", cur_dom, 2'd2);
    tick();
    chk("s2_to_err", timeout_err, 1'b1);
    chk("s2_to_cur", cur_dom, 2'd3);
    chk("s2_to_mask", dom_rst_n, 4'b0111);
    tick_n(3);
    chk("s2_gap3_mask", dom_rst_n, 4'b0111);
    tick();
    chk("s2_rel3", dom_rst_n, 4'b1111);
    chk("s2_rel3_done", done, 1'b0);
    tick();
    chk("s2_done", done, 1'b1);
    chk("s2_busy", busy, 1'b0);
    tick_n(5);
    chk("s2_sticky_err", timeout_err, 1'b1);
    chk("s2_done_hold", done, 1'b1);

    // 3: software reset pulse from DONE clears everything, then the sequence repeats.
    dom_ack = 4'b1111;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("s3_dom_rst_n", dom_rst_n, 4'b0000);
    chk("s3_busy", busy, 1'b1);
    chk("s3_done", done, 1'b0);
    chk("s3_timeout_err", timeout_err, 1'b0);
    chk("s3_cur_dom", cur_dom, 2'd0);
    check_seq(3, "s3");

    // 3b: a held request keeps everything in reset; the sequence starts once it drops.
    sw_rst_req = 1'b1;
    tick_n(6);
    chk("s3b_hold_mask", dom_rst_n, 4'b0000);
    chk("s3b_hold_busy", busy, 1'b1);
    sw_rst_req = 1'b0;
    check_seq(3, "s3b");

    // 4: async reset 3 ns after an edge while waiting for ack on domain 1.
    dom_ack = 4'b1101;
    hw_reset();
    tick_n(10);
    chk("s4_wait_cur", cur_dom, 2'd1);
    chk("s4_wait_mask", dom_rst_n, 4'b0011);
    #2;
    sync_rst_n = 1'b1;
    #1;
    chk("s4_async_mask", dom_rst_n, 4'b0000);
    chk("s4_async_cur", cur_dom, 2'd0);
    chk("s4_async_busy", busy, 1'b1);
    dom_ack = 4'b1111;
    @(posedge clk);
    #2;
    sync_rst_n = 1'b0;
    check_seq(3, "s4");

    // 5: dly_cfg=0 -> releases at edges 1, 3, 5, 7; done at 8.
    dly_cfg = 8'd0;
    hw_reset();
    check_seq(0, "s5");

    // 6: ack[1] arrives on the edge where its timeout counter is 31 -> no error.
    dly_cfg = 8'd3;
    dom_ack = 4'b1101;
    hw_reset();
    tick_n(9);
    chk("s6_rel1", dom_rst_n, 4'b0011);
    tick_n(31);
    chk("s6_edge40_cur", cur_dom, 2'd1);
    chk("s6_edge40_err", timeout_err, 1'b0);
    dom_ack = 4'b1111;
    tick();
    chk("s6_adv_cur", cur_dom, 2'd2);
    chk("s6_adv_err", timeout_err, 1'b0);
    dom_ack = 4'b1110;
    tick_n(4);
    chk("s6_rel2", dom_rst_n, 4'b0111);
    tick_n(5);
    chk("s6_rel3", dom_rst_n, 4'b1111);
    tick();
    chk("s6_done", done, 1'b1);
    chk("s6_final_err", timeout_err, 1'b0);
    chk("s6_dom0_kept", dom_rst_n[0], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
